run_pattern_gen: RTL

Serial run-length pattern generator that drives the single-bit `w` stream consumed by our run detectors (the four-equal-bits FSMs). It accepts run descriptors (bit value, run length) over a valid/ready handshake and serializes each as consecutive `w` bits. It also produces a cycle-aligned expected-detect flag, so the block works both as the transmit end of the `w` interface and as a self-checking stimulus source.

---
 rtl/run_gen_pkg.sv | 10 +
 rtl/run_streak_ctr.sv | 54 +++++
 rtl/run_pattern_gen.sv | 128 ++++++++++++
 3 files changed

// File: rtl/run_gen_pkg.sv
// Shared definitions for the run-length pattern generator and its
// streak counter: FSM state encoding and default parameter values.
package run_gen_pkg;

  typedef enum logic [0:0] {GEN_IDLE, GEN_EMIT} gen_state_e;

  localparam int unsigned RUN_THRESH_DEF = 4;
  localparam int unsigned LEN_W_DEF      = 8;

endpackage

// File: rtl/run_streak_ctr.sv
// Saturating streak counter over a single-bit stream.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   run_bit     - stream bit that will be visible next cycle
//   valid       - run_bit is a real stream bit next cycle
//   z_exp       - registered: the visible bit ends a streak of at least
//                 RUN_THRESH equal, gapless bits
// The inputs describe the next-cycle stream so that z_exp lines up with
// a stream that is itself registered.
module run_streak_ctr
  import run_gen_pkg::*;
#(
  parameter int unsigned RUN_THRESH = RUN_THRESH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_bit,
  input  logic valid,
  output logic z_exp
);

  localparam int unsigned STK_W = $clog2(RUN_THRESH + 1);

  logic [STK_W-1:0] stk;
  logic [STK_W-1:0] stk_nxt;
  logic             last_bit;
  logic             last_valid;

  always_comb begin
    stk_nxt = '0;
    if (valid) begin
      if (last_valid && (run_bit == last_bit)) begin
        stk_nxt = (stk == STK_W'(RUN_THRESH)) ? stk : stk + STK_W'(1);
      end else begin
        stk_nxt = STK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk        <= '0;
      last_bit   <= 1'b0;
      last_valid <= 1'b0;
      z_exp      <= 1'b0;
    end else begin
      stk        <= stk_nxt;
      last_bit   <= run_bit;
      last_valid <= valid;
      z_exp      <= valid && (stk_nxt == STK_W'(RUN_THRESH));
    end
  end

endmodule

// File: rtl/run_pattern_gen.sv
// Serial run-length pattern generator. Accepts (bit, length) run
// descriptors over valid/ready and serializes each as consecutive w bits,
// with a cycle-aligned expected-detect flag for the run detectors.
// Ports:
//   clk_i, res_ni  - clock, asynchronous active-low reset
//   req_valid_i    - descriptor valid
//   req_ready_o    - descriptor can be accepted (one-entry pending slot free)
//   req_bit_i      - run bit value
//   req_len_i      - run length; zero-length descriptors are dropped
//   w_o            - serial stream (registered)
//   w_valid_o      - w_o carries a run bit (registered)
//   z_exp_o        - expected detector output, aligned with w_o (registered)
//   busy_o         - emitting, or a descriptor is pending
module run_pattern_gen
  import run_gen_pkg::*;
#(
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned RUN_THRESH = RUN_THRESH_DEF
) (
  input  logic             clk_i,
  input  logic             res_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_bit_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic             w_o,
  output logic             w_valid_o,
  output logic             z_exp_o,
  output logic             busy_o
);

  gen_state_e       state, state_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic             pend_bit, pend_bit_nxt;
  logic [LEN_W-1:0] pend_len, pend_len_nxt;
  logic             w_q, w_nxt;
  logic             w_valid_q, w_valid_nxt;
  logic             acc_run;

  assign acc_run = req_valid_i && !pend_valid && (req_len_i != '0);

  always_comb begin
    state_nxt      = state;
    rem_nxt        = rem;
    pend_valid_nxt = pend_valid;
    pend_bit_nxt   = pend_bit;
    pend_len_nxt   = pend_len;
    w_nxt          = w_q;
    w_valid_nxt    = w_valid_q;
    unique case (state)
      GEN_IDLE: begin
        if (pend_valid) begin
          state_nxt      = GEN_EMIT;
          w_nxt          = pend_bit;
          w_valid_nxt    = 1'b1;
          rem_nxt        = pend_len;
          pend_valid_nxt = 1'b0;
        end else if (acc_run) begin
          state_nxt   = GEN_EMIT;
          w_nxt       = req_bit_i;
          w_valid_nxt = 1'b1;
          rem_nxt     = req_len_i;
        end
      end
      GEN_EMIT: begin
        if (rem > LEN_W'(1)) begin
          rem_nxt = rem - LEN_W'(1);
          if (acc_run) begin
            pend_valid_nxt = 1'b1;
            pend_bit_nxt   = req_bit_i;
            pend_len_nxt   = req_len_i;
          end
        end else if (pend_valid) begin
          w_nxt          = pend_bit;
          rem_nxt        = pend_len;
          pend_valid_nxt = 1'b0;
        end else if (acc_run) begin
          // Descriptor arriving on the last bit chains straight on: no gap.
          w_nxt   = req_bit_i;
          rem_nxt = req_len_i;
        end else begin
          state_nxt   = GEN_IDLE;
          w_nxt       = 1'b0;
          w_valid_nxt = 1'b0;
          rem_nxt     = '0;
        end
      end
      default: state_nxt = GEN_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      state      <= GEN_IDLE;
      rem        <= '0;
      pend_valid <= 1'b0;
      pend_bit   <= 1'b0;
      pend_len   <= '0;
      w_q        <= 1'b0;
      w_valid_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rem        <= rem_nxt;
      pend_valid <= pend_valid_nxt;
      pend_bit   <= pend_bit_nxt;
      pend_len   <= pend_len_nxt;
      w_q        <= w_nxt;
      w_valid_q  <= w_valid_nxt;
    end
  end

  run_streak_ctr #(
    .RUN_THRESH(RUN_THRESH)
  ) u_streak (
    .clk    (clk_i),
    .rst_n  (res_ni),
    .run_bit(w_nxt),
    .valid  (w_valid_nxt),
    .z_exp  (z_exp_o)
  );

  assign w_o         = w_q;
  assign w_valid_o   = w_valid_q;
  assign req_ready_o = !pend_valid;
  assign busy_o      = (state == GEN_EMIT) || pend_valid;

endmodule
